// File: rtl/arbitro_escritura_br_pkg.sv
// br_pkg: shared types for the register-bank write-port arbiter.
//   DATA_W / ADDR_W : default data and register-address widths.
//   wr_req_t        : one pending bank write {addr, data}.
//   grant_t         : identifies which requester was granted.
package br_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    GR_A = 1'b0,
    GR_B = 1'b1
  } grant_t;

endpackage

// File: rtl/arbitro_escritura_br_fifo.sv
// fifo_br: synchronous FIFO of wr_req_t with DEPTH entries (power of two).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_req : write one entry (ignored when full)
//   pop          : discard the head entry (ignored when empty)
//   head         : entry at the read pointer
//   empty, full  : occupancy flags
//   entry_valid  : per-slot occupancy, indexed by storage slot
//   entries      : raw storage, indexed by storage slot
// entry_valid/entries let the parent compare every pending address.
module fifo_br
  import br_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wr_req_t          push_req,
  input  logic             pop,
  output wr_req_t          head,
  output logic             empty,
  output logic             full,
  output logic [DEPTH-1:0] entry_valid,
  output wr_req_t          entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] count;
  logic        do_push;
  logic        do_pop;
  wr_req_t     mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_req;
  end

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the current occupancy.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]     = mem[i];
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr[PW-1:0]} < count);
    end
  end

endmodule

// File: rtl/arbitro_escritura_br.sv
// arbitro_escritura_br: write-port arbiter and hazard tracker for the 32x32
// register bank. Requesters A (ALU writeback) and B (load writeback) each
// feed a private FIFO; one FIFO head is granted per cycle, round-robin on
// ties, and loaded into a registered write stage driving the bank.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data : requester A write channel
//   b_valid/b_ready/b_addr/b_data : requester B write channel
//   rd_addr_1, rd_addr_2       : addresses on the bank read ports
//   rd_busy_1, rd_busy_2       : a pending write targets that read address
//   reg_en, wr_addr, wr_data   : registered bank write port
// Handshake: a write is transferred on a rising edge where x_valid and
// x_ready are both high; x_ready means "FIFO not full" and never depends on
// a pop in the same cycle; a requester holds valid and payload stable until
// the transfer happens.
module arbitro_escritura_br #(
  parameter int DATA_W = br_pkg::DATA_W,
  parameter int ADDR_W = br_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  output logic              reg_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  import br_pkg::*;

  wr_req_t          a_req, b_req, a_head, b_head;
  logic             a_empty, a_full, b_empty, b_full;
  logic [DEPTH-1:0] a_vld, b_vld;
  wr_req_t          a_ent [DEPTH];
  wr_req_t          b_ent [DEPTH];
  logic             grant_a, grant_b;
  grant_t           last_grant;

  assign a_req   = '{addr: a_addr, data: a_data};
  assign b_req   = '{addr: b_addr, data: b_data};
  assign a_ready = !a_full;
  assign b_ready = !b_full;

  fifo_br #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n),
    .push(a_valid && a_ready), .push_req(a_req),
    .pop(grant_a), .head(a_head),
    .empty(a_empty), .full(a_full),
    .entry_valid(a_vld), .entries(a_ent)
  );

  fifo_br #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n),
    .push(b_valid && b_ready), .push_req(b_req),
    .pop(grant_b), .head(b_head),
    .empty(b_empty), .full(b_full),
    .entry_valid(b_vld), .entries(b_ent)
  );

  // On a tie the requester that was not granted last wins.
  assign grant_a = !a_empty && (b_empty || (last_grant == GR_B));
  assign grant_b = !b_empty && (a_empty || (last_grant == GR_A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GR_B;
    end else if (grant_a) begin
      last_grant <= GR_A;
    end else if (grant_b) begin
      last_grant <= GR_B;
    end
  end

  // Output stage: address/data hold their last value when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_en  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      reg_en <= grant_a || grant_b;
      if (grant_a) begin
        wr_addr <= a_head.addr;
        wr_data <= a_head.data;
      end else if (grant_b) begin
        wr_addr <= b_head.addr;
        wr_data <= b_head.data;
      end
    end
  end

  // A write is "in flight" from FIFO entry until its bank write edge.
  always_comb begin
    rd_busy_1 = reg_en && (wr_addr == rd_addr_1);
    rd_busy_2 = reg_en && (wr_addr == rd_addr_2);
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i] && (a_ent[i].addr == rd_addr_1)) rd_busy_1 = 1'b1;
      if (a_vld[i] && (a_ent[i].addr == rd_addr_2)) rd_busy_2 = 1'b1;
      if (b_vld[i] && (b_ent[i].addr == rd_addr_1)) rd_busy_1 = 1'b1;
      if (b_vld[i] && (b_ent[i].addr == rd_addr_2)) rd_busy_2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_br.sv
// tb_arbitro_escritura_br: bench for arbitro_escritura_br. A queue-based
// reference model tracks pending writes per requester and the expected bank
// write stream; a negedge monitor compares the DUT against it.
module tb_arbitro_escritura_br;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int EW    = AW + DW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic [AW-1:0] rd_addr_1, rd_addr_2;
  logic          rd_busy_1, rd_busy_2;
  logic          reg_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  arbitro_escritura_br #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .reg_en(reg_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each requester is a bounded queue; at every edge the rules pick one
  // non-empty queue (alternating on ties), move its head to the output
  // stage and the expected write stream, then append accepted requests.
  logic [EW-1:0] qa[$], qb[$];
  logic [EW-1:0] exp_q[$];
  bit            last_was_b;
  bit            out_v;
  logic [AW-1:0] out_a;
  logic [DW-1:0] out_d;
  bit            acc_a, acc_b;
  bit            m_ga, m_gb;
  logic [EW-1:0] m_w;
  logic [DW-1:0] bank [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); exp_q.delete();
      last_was_b = 1'b1;
      out_v = 1'b0; out_a = '0; out_d = '0;
      acc_a = 1'b0; acc_b = 1'b0;
    end else begin
      acc_a = a_valid && (qa.size() < DEPTH);
      acc_b = b_valid && (qb.size() < DEPTH);
      m_ga  = (qa.size() != 0) && ((qb.size() == 0) || last_was_b);
      m_gb  = (qb.size() != 0) && ((qa.size() == 0) || !last_was_b);
      out_v = m_ga || m_gb;
      if (m_ga) begin
        m_w = qa.pop_front();
        last_was_b = 1'b0;
      end else if (m_gb) begin
        m_w = qb.pop_front();
        last_was_b = 1'b1;
      end
      if (out_v) begin
        exp_q.push_back(m_w);
        out_a = m_w[DW +: AW];
        out_d = m_w[DW-1:0];
      end
      if (acc_a) qa.push_back({a_addr, a_data});
      if (acc_b) qb.push_back({b_addr, b_data});
    end
  end

  function automatic bit model_busy(input logic [AW-1:0] r);
    foreach (qa[i]) if (qa[i][DW +: AW] == r) return 1'b1;
    foreach (qb[i]) if (qb[i][DW +: AW] == r) return 1'b1;
    return out_v && (out_a == r);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("reg_en", reg_en, out_v);
      check("wr_port", {wr_addr, wr_data}, {out_a, out_d});
      if (reg_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          check("write_order", {wr_addr, wr_data}, exp_q.pop_front());
        end
        bank[wr_addr] = wr_data;
      end
      check("a_ready", a_ready, qa.size() < DEPTH);
      check("b_ready", b_ready, qb.size() < DEPTH);
      check("rd_busy_1", rd_busy_1, model_busy(rd_addr_1));
      check("rd_busy_2", rd_busy_2, model_busy(rd_addr_2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < budget && (exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0); i++) step();
    step();
    check("drain_done", exp_q.size() + qa.size() + qb.size(), 0);
  endtask

  // Watchdog: the bench must end by itself even if the DUT locks up.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_acc;
    bit  seen_full;
    logic [DW-1:0] da, db;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_reg_en", reg_en, 1'b0);
    check("reset_wr_port", {wr_addr, wr_data}, '0);
    check("reset_ready", {a_ready, b_ready}, 2'b11);
    check("reset_busy", {rd_busy_1, rd_busy_2}, 2'b00);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single write: reg_en high for exactly one cycle after the grant edge.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    check("single_busy_pending", reg_en, 1'b0);
    step();
    check("single_reg_en", reg_en, 1'b1);
    check("single_wr", {wr_addr, wr_data}, {5'd5, 32'hDEADBEEF});
    step();
    check("single_reg_en_off", reg_en, 1'b0);

    // Hazard: B writes r7 while read port 1 looks at r7 and port 2 at r8.
    rd_addr_1 = 5'd7; rd_addr_2 = 5'd8;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0777;
    step();
    b_valid = 1'b0;
    check("hazard_busy1_fifo", rd_busy_1, 1'b1);
    check("hazard_busy2_fifo", rd_busy_2, 1'b0);
    step();
    check("hazard_busy1_stage", {reg_en, rd_busy_1}, 2'b11);
    step();
    check("hazard_busy1_clear", rd_busy_1, 1'b0);

    // Same address from both requesters on one edge: A first, B last.
    apply_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("same_addr_first", wr_data, 32'h11);
    step();
    check("same_addr_second", wr_data, 32'h22);
    step();
    check("same_addr_bank_r3", bank[3], 32'h22);

    // A alone, valid held, DEPTH+1 entries in sequence.
    n_acc = 0;
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h100;
    for (int i = 0; i < 40 && n_acc < DEPTH + 1; i++) begin
      step();
      if (acc_a) begin
        n_acc++;
        a_addr = a_addr + 1'b1; a_data = a_data + 1;
      end
    end
    a_valid = 1'b0;
    check("burst_accepts", n_acc, DEPTH + 1);
    drain(20);

    // Contention: both always valid with incrementing data.
    apply_reset();
    da = 32'hA000_0000; db = 32'hB000_0000;
    seen_full = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd1; b_addr = 5'd2; a_data = da; b_data = db;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!a_ready || !b_ready) seen_full = 1'b1;
      if (acc_a) begin da++; a_data = da; end
      if (acc_b) begin db++; b_data = db; end
    end
    check("contention_fifo_filled", seen_full, 1'b1);
    check("contention_accepts", {da - 32'hA000_0000 >= 18, db - 32'hB000_0000 >= 18}, 2'b11);
    drain(20);

    // Reset mid-operation: two A entries pending, one in the output stage.
    apply_reset();
    rd_addr_1 = 5'd10; rd_addr_2 = 5'd9;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1;
    step();
    a_addr = 5'd10; a_data = 32'h2;
    step();
    a_valid = 1'b0;
    check("midrst_pre_reg_en", reg_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_reg_en", reg_en, 1'b0);
    check("midrst_a_ready", a_ready, 1'b1);
    check("midrst_busy", {rd_busy_1, rd_busy_2}, 2'b00);
    step();
    check("midrst_no_write", reg_en, 1'b0);
    rst_n = 1'b1;
    step(); step();
    check("midrst_after", reg_en, 1'b0);

    // Randomized traffic with valid held until accepted.
    for (int i = 0; i < 1500; i++) begin
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = AW'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = AW'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      rd_addr_1 = AW'($urandom_range(0, 7));
      rd_addr_2 = AW'($urandom_range(0, 9));
      step();
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_escritura_br.md
# arbitro_escritura_br

Write-port arbiter and hazard tracker for the 32x32 register bank. Two writeback sources share the bank's single write port: A is ALU writeback and B is load writeback. Each source has its own small FIFO, and the arbiter drains both FIFOs round-robin into one registered write per cycle, driving the bank's write-enable, write address and write data. It also reports whether either of the bank's read addresses has a write still in flight, so the sequencer can stall.

## Interface
Parameters:
- DATA_W, 32, data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A FIFO not full.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid, b_ready, b_addr, b_data: same as the A ports, for requester B.
- rd_addr_1, rd_addr_2  in  ADDR_W  addresses currently presented to the bank read ports.
- rd_busy_1, rd_busy_2  out  1  a pending write targets rd_addr_1 / rd_addr_2.
- reg_en  out  1  bank write enable, registered.
- wr_addr  out  ADDR_W  bank write address, registered.
- wr_data  out  DATA_W  bank write data, registered.

## Operation
- **Accept.** A request is accepted on a rising edge where x_valid && x_ready. x_ready = !full(x) and does not depend on a same-cycle pop.
- **Arbitration.** Each cycle the arbiter grants at most one non-empty FIFO.
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the FIFO that was not granted most recently (last_grant).
  - Neither non-empty: no grant.
- **Grant.** The granted FIFO pops its head, and the output stage loads reg_en=1, wr_addr and wr_data at the same edge. With no grant, reg_en=0 at that edge and wr_addr/wr_data hold.
- **Ordering.** Order within one requester is preserved. Order across requesters follows grant order, including writes to the same register; no coalescing.
- **Register 0.** Address 0 is written like any other register; there is no special handling.
- **rd_busy_k.** Combinational OR of address matches against rd_addr_k. Candidates are every valid entry of both FIFOs plus the output stage when reg_en=1.
- **Push and pop in one cycle.** Allowed on a non-full FIFO; occupancy is unchanged.
- **FIFO full.** Accepts nothing until a pop.
- **Wrap-around.** FIFO pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.

## Timing
- **Latency.** Accept at edge N, grant at edge N+1 at the earliest, reg_en high in the cycle after N+1, bank write at edge N+2.
- **Throughput.** One bank write per cycle sustained. Each requester gets at least one write every 2 cycles under contention.
- **Reset values (while rst_n=0, immediately and asynchronously):**
  - reg_en=0, wr_addr=0, wr_data=0.
  - Both FIFOs empty, so a_ready=b_ready=1.
  - rd_busy_1=rd_busy_2=0.
  - last_grant=B, so A wins the first tie.
- **Reset mid-operation.** Pending entries are discarded and no write reaches the bank. If reg_en was high, it drops asynchronously and no write occurs at the next edge.
- **Busy window.** rd_busy asserts in the cycle after the accept edge and stays asserted through the cycle in which reg_en=1 for that entry. It clears after the bank write edge unless another pending write matches.

## Structure
- **Package br_pkg:**
  - DATA_W and ADDR_W defaults.
  - Typedef wr_req_t {addr, data}.
  - Enum grant_t {GR_A, GR_B}.
- **Sub-module fifo_br:** synchronous FIFO of wr_req_t, DEPTH entries, instantiated twice. It exposes an entry-valid vector and its entry contents so the top level can do the busy compare.
- **Top level:** arbiter, last_grant register, output stage, and busy comparators.

## Test plan
- **Single write:** A pushes addr=5, data=0xDEADBEEF at edge 1 -> reg_en=1 and wr_addr=5, wr_data=0xDEADBEEF during cycle 2 only; reg_en=0 in cycle 3.
- **Contention:** after reset, A and B both valid every cycle with incrementing data -> grants alternate A,B,A,B starting with A. Each FIFO fills, x_ready drops, and accepts settle to one per requester every 2 cycles. No request is lost or reordered within a requester.
- **Full FIFO:** B stalled empty; push DEPTH+1 entries on A while a_valid is held continuously -> no entry is dropped, and the writes appear in push order.
- **Same address:** A and B both push addr=3 on the same edge, A data 0x11 and B data 0x22, after reset -> 0x11 is written first, then 0x22; final bank r3=0x22.
- **Hazard:** B pushes addr=7 with rd_addr_1=7 and rd_addr_2=8 -> rd_busy_1=1 from the next cycle through the reg_en cycle, then 0; rd_busy_2=0 throughout.
- **Reset mid-operation:** two A entries pending and reg_en=1; drop rst_n mid-cycle -> reg_en=0 immediately, no bank write at the following edges, a_ready=1, rd_busy_*=0.
